muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle controller/datapath for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   Sits beside the single-cycle ALU; the decoder routes M-ext ops (funct7=0000001) here.
//   Holds the core in stall while busy and returns one XLEN result with a done pulse.
//   Radix-2: one shift-add (mul) or shift-subtract restoring step (div) per cycle.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//   clk     in   1     clock, all state on rising edge
//   rst     in   1     asynchronous, active-high reset
//   start   in   1     launch op; sampled only in IDLE
//   flush   in   1     synchronous abort (branch/trap); wins over all else except rst
//   funct3  in   3     RV32M funct3: 000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//   op_a    in   XLEN  rs1 value (multiplicand/dividend), captured with start
//   op_b    in   XLEN  rs2 value (multiplier/divisor), captured with start
//   busy    out  1     high in PREP/CALC/FIX; core stalls on busy|start
//   done    out  1     one-cycle pulse, result valid this cycle
//   result  out  XLEN  final value; held stable until next accepted start
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, counter=0, all operand regs=0.
//   States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 latches funct3/op_a/op_b, -> PREP. start while not IDLE is ignored.
//   PREP: signedness per funct3 (mulh: a,b signed; mulhsu: a signed, b unsigned;
//     div/rem: both signed; others unsigned). Take magnitudes, record result sign:
//     mul sign = sa^sb; quotient sign = sa^sb; remainder sign = sign of dividend.
//     Shortcuts (PREP -> DONE, no CALC): div-by-zero (op_b==0): quotient=all ones,
//     remainder=op_a. Signed overflow (op_a=0x80000000, op_b=-1, div/rem): quotient=0x80000000,
//     remainder=0. Otherwise counter=0, -> CALC.
//   CALC: exactly XLEN cycles; counter increments 0..XLEN-1, -> FIX when counter==XLEN-1.
//     Mul: 2*XLEN-bit product accumulator, add multiplicand if lsb of multiplier, shift right.
//     Div: shift {rem,quot} left 1, trial subtract divisor, keep if non-negative, set quot lsb.
//   FIX: negate product/quotient/remainder if sign flag set (two's complement, XLEN or 2*XLEN).
//     Select low word (mul) or high word (mulh/mulhsu/mulhu), quotient or remainder. -> DONE.
//   DONE: result register updated on entry, done=1 for this single cycle, busy=0, -> IDLE.
//     start is not accepted in DONE; core re-issues next op in the following IDLE cycle.
//   Latency: start at cycle N -> done at N+XLEN+3 (35 for XLEN=32); shortcuts -> done at N+2.
//   flush=1 in any state: -> IDLE next cycle, busy=0, done=0, result unchanged, counter=0.
//   flush and start together in IDLE: flush wins, op not accepted.
//   rst asserted mid-operation: immediate return to reset values, no done pulse.
//   Products/quotients are modulo 2^XLEN; no exceptions are raised (RISC-V semantics).
// TESTING
//   mul 7*(-3): op_a=7, op_b=0xFFFFFFFD, funct3=000 -> done at +35, result=0xFFFFFFEB.
//   mulh/mulhu 0x80000000*0x80000000 -> mulh=0x40000000, mulhu=0x40000000; mulhsu(-1,0xFFFFFFFF)=0xFFFFFFFF.
//   div -7/2 -> 0xFFFFFFFD; rem -7%2 -> 0xFFFFFFFF; divu 100/7=14, remu=2, all at +35.
//   divu 5/0 -> 0xFFFFFFFF, rem 5/0 -> 5, div 0x80000000/-1 -> 0x80000000, done at +2.
//   flush at CALC cycle 10 -> busy=0 next cycle, no done, result retains prior value; restart ok.
//   start held high through busy/DONE -> exactly one op per accepted start; rst mid-CALC -> all zero.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Radix-2 sequential RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, magnitude datapath with sign fix-up at the end.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_f3;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  // mul: {product_hi, multiplier/product_lo}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mc;
  logic [CW-1:0]       r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_sa_en;
  logic                w_sb_en;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_amag;
  logic [XLEN-1:0]     w_bmag;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN:0]       w_msum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_sh;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_fix_res;

  assign w_is_div = r_f3[2];
  assign w_sa_en  = (r_f3 == 3'b001) || (r_f3 == 3'b010) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
  assign w_sb_en  = (r_f3 == 3'b001) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
  assign w_sa     = w_sa_en & r_a[XLEN-1];
  assign w_sb     = w_sb_en & r_b[XLEN-1];
  assign w_amag   = w_sa ? (-r_a) : r_a;
  assign w_bmag   = w_sb ? (-r_b) : r_b;
  assign w_div0   = (r_b == '0);
  assign w_ovf    = w_is_div & ~r_f3[0] & (r_a == MIN_NEG) & (&r_b);

  assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mc};
  assign w_mul_nxt = r_acc[0] ? {w_msum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Kept differences are always below the divisor, so XLEN bits suffice.
  assign w_sh      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge      = (w_sh >= {1'b0, r_mc});
  assign w_diff    = w_sh[XLEN-1:0] - r_mc;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                          : {w_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg_q ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_r ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod_fix[XLEN-1:0];
    case (r_f3)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo_fix;
      default:                w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_f3    <= funct3;
            r_a     <= op_a;
            r_b     <= op_b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (w_is_div && w_div0) begin
            r_result <= r_f3[1] ? r_a : '1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_ovf) begin
            r_result <= r_f3[1] ? '0 : MIN_NEG;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_acc   <= w_is_div ? {{XLEN{1'b0}}, w_amag} : {{XLEN{1'b0}}, w_bmag};
            r_mc    <= w_is_div ? w_bmag : w_amag;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_nxt : w_mul_nxt;
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: RV32M arithmetic model with cycle-level latency
// tracking, directed corner ops, flush/reset/held-start scenarios, random traffic.
module tb_muldiv_sequencer;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb, sq;
    sa = a; sb = b;
    ref_res = '0;
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; ref_res = up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); ref_res = sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); ref_res = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; ref_res = up[63:32]; end
      3'd4: begin
        if (b == 0) ref_res = '1;
        else if (a == MINV && b == '1) ref_res = MINV;
        else begin sq = sa / sb; ref_res = sq; end
      end
      3'd5: ref_res = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) ref_res = a;
        else if (a == MINV && b == '1) ref_res = '0;
        else begin sq = sa % sb; ref_res = sq; end
      end
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MINV && b == '1))) return 2;
    return 35;
  endfunction

  // Model: 0 idle, 1 busy, 2 done-cycle
  int          m_phase = 0;
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_left <= 0; m_res <= '0;
    end else if (flush) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_left  <= ref_lat(funct3, op_a, op_b) - 1;
          m_pend  <= ref_res(funct3, op_a, op_b);
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin m_phase <= 2; m_res <= m_pend; end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_phase == 1});
      chk("done", {31'b0, done}, {31'b0, m_phase == 2});
      chk("result", result, m_res);
    end
  end

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    @(posedge clk); #3;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #3;
    start = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk({name, "_lat"}, cyc, lat);
    chk(name, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return $urandom % 16;
      5: return 32'h0 - ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op("mul_7x-3",   3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    do_op("mulh_min",   3'b001, MINV, MINV, 32'h4000_0000, 35);
    do_op("mulhu_min",  3'b011, MINV, MINV, 32'h4000_0000, 35);
    do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    do_op("div_-7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    do_op("rem_-7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 35);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 35);
    do_op("divu_5_0",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    do_op("rem_5_0",    3'b110, 32'd5, 32'd0, 32'd5, 2);
    do_op("div_ovf",    3'b100, MINV, 32'hFFFF_FFFF, MINV, 2);
    do_op("rem_ovf",    3'b110, MINV, 32'hFFFF_FFFF, 32'd0, 2);

    // flush during CALC iteration 10
    @(posedge clk); #3;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #3;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3 flush = 1'b1;
    @(posedge clk); #3;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    cnt = 0;
    repeat (45) begin @(negedge clk); if (done) cnt++; end
    chk("flush_nodone", cnt, 0);
    chk("flush_keep", result, 32'd0);
    do_op("after_flush", 3'b000, 32'd9, 32'd9, 32'd81, 35);

    // start held high: one op per acceptance, none in the DONE cycle
    @(posedge clk); #3;
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
    cnt = 0;
    for (int i = 0; i < 72; i++) begin @(negedge clk); if (done) cnt++; end
    @(posedge clk); #3;
    start = 1'b0;
    repeat (40) begin @(negedge clk); if (done) cnt++; end
    chk("hold_count", cnt, 2);
    chk("hold_result", result, 32'd333);

    // reset mid-CALC
    @(posedge clk); #3;
    start = 1'b1; funct3 = 3'b001; op_a = 32'h1234_5678; op_b = 32'h8765_4321;
    @(posedge clk); #3;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    chk("rstmid_result", result, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    // random traffic with occasional flush and reset
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #3;
      rst    = ($urandom % 1500) == 0;
      start  = ($urandom % 3) == 0;
      flush  = ($urandom % 60) == 0;
      funct3 = 3'($urandom % 8);
      op_a   = pick();
      op_b   = pick();
    end
    @(posedge clk); #3;
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);
    do_op("final_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
